// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared types and helpers for the load/store unit sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

  // Sequencer state, kept as plain 2-bit constants for legacy tool flows
  typedef logic [1:0] lsu_state_t;

  localparam lsu_state_t LSU_IDLE   = 2'd0;
  localparam lsu_state_t LSU_ACCESS = 2'd1;
  localparam lsu_state_t LSU_DONE   = 2'd2;
  localparam lsu_state_t LSU_HALT   = 2'd3;

  // Lane counter width; a single-lane build still needs one bit of counter
  function automatic int lsu_lane_w(input int threads);
    return (threads > 1) ? $clog2(threads) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_buffer.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_buffer
// Description : Per-lane 32-bit load data registers, one lane written per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_buffer #(
  parameter int THREADS = 4,
  parameter int LW      = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     we_i,
  input  logic [LW-1:0]            lane_i,
  input  logic [31:0]              wdata_i,
  output logic [THREADS-1:0][31:0] data_o
);

  logic [THREADS-1:0][31:0] buf_q;

  for (genvar g = 0; g < THREADS; g++) begin : g_lane
    // Capture load data only into the addressed lane; others keep their value
    always_ff @(posedge CLK) begin
      if (RST) begin
        buf_q[g] <= '0;
      end else if (we_i && (lane_i == LW'(g))) begin
        buf_q[g] <= wdata_i;
      end
    end
  end

  assign data_o = buf_q;

endmodule
`default_nettype wire

// File: rtl/lsu_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lsu_access_sequencer
// Description : Serializes scalar/vector loads and stores into single-word
//               dcache accesses, passes ifetch through, sequences halt/flush.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_access_sequencer
  import cpu_types_pkg::*;
#(
  parameter int CPUS    = 2,
  parameter int CPUID   = 0,
  parameter int THREADS = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     instReq,
  input  logic [31:0]              iaddr,
  input  logic                     readReq,
  input  logic                     writeReq,
  input  logic                     isVector,
  input  logic                     dhalt,
  input  logic [THREADS-1:0][31:0] vdaddr,
  input  logic [THREADS-1:0][31:0] vdstore,
  input  logic [31:0]              sdaddr,
  input  logic [31:0]              sdstore,
  output logic                     iHit,
  output logic [31:0]              iload,
  output logic                     dHit,
  output logic [THREADS-1:0][31:0] vdload,
  output logic [31:0]              sdload,
  output logic                     imemREN,
  output logic [31:0]              imemaddr,
  input  logic [31:0]              imemload,
  input  logic                     icacheHit,
  output logic                     dmemREN,
  output logic                     dmemWEN,
  output logic [31:0]              dmemaddr,
  output logic [31:0]              dmemstore,
  input  logic [31:0]              dmemload,
  input  logic                     dcacheHit,
  output logic                     chalt,
  input  logic                     flushed
);

  localparam int LW = lsu_lane_w(THREADS);

  lsu_state_t    state_q, state_d;
  logic [LW-1:0] lane_q,  lane_d;
  logic          wr_q,    wr_d;
  logic          vec_q,   vec_d;
  logic [31:0]   sdload_q, sdload_d;

  logic          w_access;
  logic          w_halted;
  logic          w_last;
  logic          w_capture;
  logic [31:0]   w_addr;
  logic [31:0]   w_store;
  logic          w_unused;

  // HALT is only left through reset, so flush completion has no effect here;
  // CPUS/CPUID are informational.
  assign w_unused = &{1'b0, flushed, 32'(CPUS), 32'(CPUID)};

  assign w_access  = (state_q == LSU_ACCESS);
  assign w_halted  = (state_q == LSU_HALT);
  // Datapath holds addresses/data stable until dHit, so the live inputs are muxed
  assign w_addr    = vec_q ? vdaddr[lane_q]  : sdaddr;
  assign w_store   = vec_q ? vdstore[lane_q] : sdstore;
  // Last lane always exits, so the counter can never wrap
  assign w_last    = ~vec_q | (lane_q == LW'(THREADS - 1));
  assign w_capture = w_access & dcacheHit & ~wr_q;

  // Next-state logic for the access sequencer
  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    wr_d     = wr_q;
    vec_d    = vec_q;
    sdload_d = sdload_q;
    case (state_q)
      LSU_IDLE: begin
        if (readReq | writeReq) begin
          wr_d    = writeReq;
          vec_d   = isVector;
          lane_d  = '0;
          state_d = LSU_ACCESS;
        end else if (dhalt) begin
          state_d = LSU_HALT;
        end
      end
      LSU_ACCESS: begin
        if (dcacheHit) begin
          if (~wr_q & ~vec_q) begin
            sdload_d = dmemload;
          end
          if (w_last) begin
            state_d = LSU_DONE;
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      LSU_DONE: state_d = LSU_IDLE;
      LSU_HALT: state_d = LSU_HALT;
      default:  state_d = LSU_IDLE;
    endcase
  end

  // State, lane counter, op latches and scalar load register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= LSU_IDLE;
      lane_q   <= '0;
      wr_q     <= 1'b0;
      vec_q    <= 1'b0;
      sdload_q <= '0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      wr_q     <= wr_d;
      vec_q    <= vec_d;
      sdload_q <= sdload_d;
    end
  end

  lsu_lane_buffer #(
    .THREADS (THREADS),
    .LW      (LW)
  ) u_lane_buffer (
    .CLK     (CLK),
    .RST     (RST),
    .we_i    (w_capture & vec_q),
    .lane_i  (lane_q),
    .wdata_i (dmemload),
    .data_o  (vdload)
  );

  assign sdload    = sdload_q;

  assign dmemREN   = w_access & ~wr_q;
  assign dmemWEN   = w_access &  wr_q;
  assign dmemaddr  = w_access ? w_addr  : '0;
  assign dmemstore = w_access ? w_store : '0;
  assign dHit      = (state_q == LSU_DONE);
  assign chalt     = w_halted;

  // Instruction fetch is a pass-through, gated off once the core is halted
  assign imemREN   = instReq & ~w_halted;
  assign imemaddr  = iaddr;
  assign iload     = imemload;
  assign iHit      = instReq & icacheHit & ~w_halted;

endmodule
`default_nettype wire

// File: tb/tb_lsu_access_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_lsu_access_sequencer
// Description : Scoreboard bench for the LSU access sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_access_sequencer;

  localparam int THREADS = 4;

  logic                     CLK = 1'b0;
  logic                     RST = 1'b1;
  logic                     instReq = 1'b0;
  logic [31:0]              iaddr = '0;
  logic                     readReq = 1'b0;
  logic                     writeReq = 1'b0;
  logic                     isVector = 1'b0;
  logic                     dhalt = 1'b0;
  logic [THREADS-1:0][31:0] vdaddr = '0;
  logic [THREADS-1:0][31:0] vdstore = '0;
  logic [31:0]              sdaddr = '0;
  logic [31:0]              sdstore = '0;
  logic                     iHit;
  logic [31:0]              iload;
  logic                     dHit;
  logic [THREADS-1:0][31:0] vdload;
  logic [31:0]              sdload;
  logic                     imemREN;
  logic [31:0]              imemaddr;
  logic [31:0]              imemload = '0;
  logic                     icacheHit = 1'b0;
  logic                     dmemREN;
  logic                     dmemWEN;
  logic [31:0]              dmemaddr;
  logic [31:0]              dmemstore;
  logic [31:0]              dmemload;
  logic                     dcacheHit = 1'b0;
  logic                     chalt;
  logic                     flushed = 1'b0;

  lsu_access_sequencer #(.CPUS(2), .CPUID(0), .THREADS(THREADS)) dut (
    .CLK(CLK), .RST(RST), .instReq(instReq), .iaddr(iaddr),
    .readReq(readReq), .writeReq(writeReq), .isVector(isVector), .dhalt(dhalt),
    .vdaddr(vdaddr), .vdstore(vdstore), .sdaddr(sdaddr), .sdstore(sdstore),
    .iHit(iHit), .iload(iload), .dHit(dHit), .vdload(vdload), .sdload(sdload),
    .imemREN(imemREN), .imemaddr(imemaddr), .imemload(imemload), .icacheHit(icacheHit),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dmemload(dmemload), .dcacheHit(dcacheHit), .chalt(chalt), .flushed(flushed)
  );

  always #5 CLK = ~CLK;

  // Cache model: a read returns the address plus one
  assign dmemload = dmemaddr + 32'd1;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  typedef struct packed {
    logic [THREADS-1:0][31:0] vd;
    logic [31:0]              sd;
  } resp_t;

  acc_t  exp_acc[$];
  resp_t exp_resp[$];
  logic [THREADS-1:0][31:0] m_vd = '0;
  logic [31:0]              m_sd = '0;

  int checks = 0;
  int errors = 0;
  int hit_mode = 1;        // 0 random hits, 1 always hit, 2 driven by the test
  bit mon_fetch_en = 1'b1;
  bit drv_fetch = 1'b1;

  function automatic void chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Reference model: expand a request into its word accesses and the final load image
  task automatic push_expect(input bit wr, input bit vec);
    acc_t  a;
    resp_t r;
    int    n;
    n = vec ? THREADS : 1;
    for (int l = 0; l < n; l++) begin
      a.wr   = wr;
      a.addr = vec ? vdaddr[l]  : sdaddr;
      a.data = vec ? vdstore[l] : sdstore;
      exp_acc.push_back(a);
      if (!wr) begin
        if (vec) m_vd[l] = a.addr + 32'd1;
        else     m_sd    = a.addr + 32'd1;
      end
    end
    r.vd = m_vd;
    r.sd = m_sd;
    exp_resp.push_back(r);
  endtask

  // Random dcache hit generator
  initial begin
    forever begin
      @(posedge CLK); #1;
      if (hit_mode == 0)      dcacheHit = ($urandom_range(0, 3) != 0);
      else if (hit_mode == 1) dcacheHit = 1'b1;
    end
  end

  // Random instruction fetch traffic running alongside data accesses
  initial begin
    forever begin
      @(posedge CLK); #1;
      if (drv_fetch) begin
        instReq   = 1'($urandom_range(0, 1));
        icacheHit = 1'($urandom_range(0, 1));
        iaddr     = $urandom;
        imemload  = $urandom;
      end
    end
  end

  // Monitor: compare each completed dcache access and each dHit against the queues
  always @(negedge CLK) begin
    acc_t  a;
    resp_t r;
    if (!RST) begin
      if ((dmemREN | dmemWEN) && dcacheHit) begin
        if (exp_acc.size() == 0) begin
          checks++; errors++;
          $display("FAIL acc_unexpected actual addr=%0h wen=%0b required none", dmemaddr, dmemWEN);
        end else begin
          a = exp_acc.pop_front();
          chk("acc_wen", dmemWEN, a.wr);
          chk("acc_ren", dmemREN, !a.wr);
          chk("acc_addr", dmemaddr, a.addr);
          if (a.wr) chk("acc_data", dmemstore, a.data);
        end
      end
      if (dHit) begin
        if (exp_resp.size() == 0) begin
          checks++; errors++;
          $display("FAIL dhit_unexpected actual=1 required=0");
        end else begin
          r = exp_resp.pop_front();
          chk("resp_vdload", vdload, r.vd);
          chk("resp_sdload", sdload, r.sd);
        end
      end
      if (mon_fetch_en)
        chk("fetch", {imemREN, iHit, imemaddr, iload},
            {instReq, instReq & icacheHit, iaddr, imemload});
    end
  end

  // Issue one request, hold it until dHit, measure latency and strobe cycles
  task automatic run_req(input bit rd, input bit wr, input bit vec, input int miss,
                         input int halt_at, output int lat, output int ren_c, output int wen_c);
    int saved_mode;
    saved_mode = hit_mode;
    @(posedge CLK); #1;
    readReq = rd; writeReq = wr; isVector = vec;
    push_expect(wr, vec);
    if (miss >= 0) begin
      hit_mode  = 2;
      dcacheHit = 1'b0;
    end
    lat = -1; ren_c = 0; wen_c = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge CLK);
      ren_c += int'(dmemREN);
      wen_c += int'(dmemWEN);
      if (dHit) begin
        lat = c;
        break;
      end
      @(posedge CLK); #1;
      if (miss >= 0) dcacheHit = (c + 1 > miss);
      if (halt_at >= 0 && c + 1 == halt_at) dhalt = 1'b1;
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL req_timeout actual=no dHit in 200 cycles required=dHit");
    end
    @(posedge CLK); #1;
    readReq = 1'b0; writeReq = 1'b0;
    hit_mode = saved_mode;
    @(negedge CLK);
    chk("dhit_pulse", dHit, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, rc, wc, kind;
    // Reset state
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("reset_out", {dmemREN, dmemWEN, dHit, chalt, dmemaddr, dmemstore}, '0);

    // Reset in the middle of a vector load aborts it
    for (int l = 0; l < THREADS; l++) vdaddr[l] = 32'h300 + 32'(4 * l);
    @(posedge CLK); #1;
    readReq = 1'b1; isVector = 1'b1;
    push_expect(1'b0, 1'b1);
    repeat (3) @(negedge CLK);
    @(posedge CLK); #1;
    RST = 1'b1; readReq = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    exp_acc.delete(); exp_resp.delete();
    m_vd = '0; m_sd = '0;
    @(negedge CLK);
    chk("midreset_strobes", {dmemREN, dmemWEN, dHit, chalt}, 4'b0000);
    chk("midreset_vdload", vdload, m_vd);
    chk("midreset_sdload", sdload, m_sd);

    // Vector load, all hits
    for (int l = 0; l < THREADS; l++) vdaddr[l] = 32'h100 + 32'(4 * l);
    run_req(1'b1, 1'b0, 1'b1, -1, -1, lat, rc, wc);
    chk("vload_latency", 32'(lat), 32'(THREADS + 1));
    chk("vload_ren_cycles", 32'(rc), 32'(THREADS));
    chk("vload_wen_cycles", 32'(wc), 32'd0);

    // Scalar load, all hits
    sdaddr = 32'h0000_0A40;
    run_req(1'b1, 1'b0, 1'b0, -1, -1, lat, rc, wc);
    chk("sload_latency", 32'(lat), 32'd2);

    // Scalar store with three miss cycles
    sdaddr = 32'h200; sdstore = 32'hDEADBEEF;
    run_req(1'b0, 1'b1, 1'b0, 3, -1, lat, rc, wc);
    chk("sstore_latency", 32'(lat), 32'd5);
    chk("sstore_wen_cycles", 32'(wc), 32'd4);
    chk("sstore_ren_cycles", 32'(rc), 32'd0);

    // Read and write together on a vector: write wins
    for (int l = 0; l < THREADS; l++) begin
      vdaddr[l]  = 32'h400 + 32'(8 * l);
      vdstore[l] = $urandom;
    end
    run_req(1'b1, 1'b1, 1'b1, -1, -1, lat, rc, wc);
    chk("rw_ren_cycles", 32'(rc), 32'd0);
    chk("rw_wen_cycles", 32'(wc), 32'(THREADS));

    // Randomized traffic with random dcache misses and concurrent fetches
    hit_mode = 0;
    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 2));
      for (int l = 0; l < THREADS; l++) begin
        vdaddr[l]  = $urandom;
        vdstore[l] = $urandom;
      end
      sdaddr  = $urandom;
      sdstore = $urandom;
      run_req(kind != 1, kind != 0, 1'($urandom_range(0, 1)), -1, -1, lat, rc, wc);
    end

    // Halt requested during lane 1 of a vector load is deferred until IDLE
    hit_mode = 1;
    for (int l = 0; l < THREADS; l++) vdaddr[l] = 32'h800 + 32'(4 * l);
    run_req(1'b1, 1'b0, 1'b1, -1, 2, lat, rc, wc);
    chk("halt_vload_latency", 32'(lat), 32'(THREADS + 1));
    mon_fetch_en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      if (chalt) break;
    end
    chk("halt_chalt", chalt, 1'b1);
    drv_fetch = 1'b0;
    @(posedge CLK); #1;
    instReq = 1'b1; icacheHit = 1'b1;
    flushed = 1'b1; readReq = 1'b1; writeReq = 1'b1; isVector = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      chk("halt_hold", {chalt, imemREN, iHit, dmemREN, dmemWEN, dHit}, 6'b100000);
    end
    readReq = 1'b0; writeReq = 1'b0;

    chk("acc_queue_empty", 32'(exp_acc.size()), 32'd0);
    chk("resp_queue_empty", 32'(exp_resp.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
